// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped table of tagged 2-bit saturating
// counters with stored branch targets, read in fetch and trained in execute.
// Optional statistics counters are compiled in when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic [31:0] TargetE,
  input  logic        TakeBranchE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE
`ifdef BP_STATS_EN
  ,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
`endif
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic                validQ  [ENTRIES];
  logic [TAG_BITS-1:0] tagQ    [ENTRIES];
  logic [31:0]         targetQ [ENTRIES];
  logic [1:0]          ctrQ    [ENTRIES];

  logic [IDX_BITS-1:0] fetchIdx;
  logic [TAG_BITS-1:0] fetchTag;
  logic                fetchHit;
  logic [IDX_BITS-1:0] execIdx;
  logic [TAG_BITS-1:0] execTag;
  logic                execHit;

  assign fetchIdx = PCF[IDX_BITS+1:2];
  assign fetchTag = PCF[31:IDX_BITS+2];
  assign execIdx  = PCE[IDX_BITS+1:2];
  assign execTag  = PCE[31:IDX_BITS+2];

  // Fetch-side lookup reads the registered table, so a same-cycle update is not visible yet
  always_comb begin
    fetchHit    = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);
    PredTakenF  = fetchHit && ctrQ[fetchIdx][1];
    PredTargetF = PCF + 32'd4;
    if (PredTakenF) begin
      PredTargetF = targetQ[fetchIdx];
    end
  end

  // Execute-side resolution: flush on wrong direction or wrong taken target
  always_comb begin
    execHit     = validQ[execIdx] && (tagQ[execIdx] == execTag);
    MispredictE = UpdateE && ((PredTakenE != TakeBranchE) ||
                              (PredTakenE && TakeBranchE && (PredTargetE != TargetE)));
    RedirectPCE = TakeBranchE ? TargetE : (PCE + 32'd4);
  end

  // Table training: hits step the counter, misses replace the entry with a weak state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        ctrQ[i]   <= 2'b01;
      end
    end else if (UpdateE) begin
      if (execHit) begin
        if (TakeBranchE) begin
          ctrQ[execIdx]    <= (ctrQ[execIdx] == 2'b11) ? 2'b11 : ctrQ[execIdx] + 2'd1;
          targetQ[execIdx] <= TargetE;
        end else begin
          ctrQ[execIdx] <= (ctrQ[execIdx] == 2'b00) ? 2'b00 : ctrQ[execIdx] - 2'd1;
        end
      end else begin
        validQ[execIdx]  <= 1'b1;
        tagQ[execIdx]    <= execTag;
        targetQ[execIdx] <= TargetE;
        ctrQ[execIdx]    <= TakeBranchE ? 2'b10 : 2'b01;
      end
    end
  end

`ifdef BP_STATS_EN
  // Resolved-branch and misprediction counters, wrapping naturally at 32 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCount     <= 32'd0;
      MispredictCount <= 32'd0;
    end else begin
      if (UpdateE) begin
        BranchCount <= BranchCount + 32'd1;
      end
      if (MispredictE) begin
        MispredictCount <= MispredictCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vectors with literal expectations,
// plus a table-level model checked against the DUT on every falling edge.
module tb_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int IDX_BITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic [31:0] TargetE;
  logic        TakeBranchE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
`ifdef BP_STATS_EN
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;
`endif

  int errors = 0;
  int checks = 0;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk),
    .reset(reset),
    .PCF(PCF),
    .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF),
    .UpdateE(UpdateE),
    .PCE(PCE),
    .TargetE(TargetE),
    .TakeBranchE(TakeBranchE),
    .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE),
    .MispredictE(MispredictE),
    .RedirectPCE(RedirectPCE)
`ifdef BP_STATS_EN
    ,
    .BranchCount(BranchCount),
    .MispredictCount(MispredictCount)
`endif
  );

  always #5 clk = ~clk;

  // Model state: one record per entry, counter held as a plain integer 0..3
  bit          mValid  [ENTRIES];
  logic [31:0] mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  bit          modelReady = 1'b0;
  logic [31:0] mBranch;
  logic [31:0] mMisp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic upd, input logic [31:0] pce,
                               input logic [31:0] tgt, input logic take, input logic ptk,
                               input logic [31:0] ptg, input logic [31:0] pcf);
    @(posedge clk);
    #1;
    reset       = rst;
    UpdateE     = upd;
    PCE         = pce;
    TargetE     = tgt;
    TakeBranchE = take;
    PredTakenE  = ptk;
    PredTargetE = ptg;
    PCF         = pcf;
    #1;
  endtask

  task automatic idle(input logic [31:0] pcf);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, pcf);
  endtask

  // Model update on each rising edge from the inputs held during the cycle
  logic [31:0] uTag;
  int          uIdx;
  bit          uMisp;
  always @(posedge clk) begin
    uIdx  = int'((PCE >> 2) % ENTRIES);
    uTag  = PCE >> (IDX_BITS + 2);
    uMisp = UpdateE && ((PredTakenE != TakeBranchE) ||
                        (PredTakenE && TakeBranchE && (PredTargetE != TargetE)));
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mValid[i] = 1'b0;
        mCtr[i]   = 1;
      end
      mBranch    = 32'd0;
      mMisp      = 32'd0;
      modelReady = 1'b1;
    end else if (UpdateE) begin
      mBranch = mBranch + 32'd1;
      if (uMisp) mMisp = mMisp + 32'd1;
      if (mValid[uIdx] && mTag[uIdx] == uTag) begin
        if (TakeBranchE) begin
          mCtr[uIdx]    = (mCtr[uIdx] < 3) ? mCtr[uIdx] + 1 : 3;
          mTarget[uIdx] = TargetE;
        end else begin
          mCtr[uIdx] = (mCtr[uIdx] > 0) ? mCtr[uIdx] - 1 : 0;
        end
      end else begin
        mValid[uIdx]  = 1'b1;
        mTag[uIdx]    = uTag;
        mTarget[uIdx] = TargetE;
        mCtr[uIdx]    = TakeBranchE ? 2 : 1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  int          cIdx;
  bit          cTaken;
  logic [31:0] cTarget;
  bit          cMisp;
  always @(negedge clk) begin
    if (modelReady) begin
      cIdx    = int'((PCF >> 2) % ENTRIES);
      cTaken  = mValid[cIdx] && (mTag[cIdx] == (PCF >> (IDX_BITS + 2))) && (mCtr[cIdx] >= 2);
      cTarget = cTaken ? mTarget[cIdx] : PCF + 32'd4;
      cMisp   = UpdateE && ((PredTakenE != TakeBranchE) ||
                            (PredTakenE && TakeBranchE && (PredTargetE != TargetE)));
      checkOutput("model PredTakenF", {31'd0, PredTakenF}, {31'd0, cTaken});
      checkOutput("model PredTargetF", PredTargetF, cTarget);
      checkOutput("model MispredictE", {31'd0, MispredictE}, {31'd0, cMisp});
      checkOutput("model RedirectPCE", RedirectPCE, TakeBranchE ? TargetE : PCE + 32'd4);
`ifdef BP_STATS_EN
      checkOutput("model BranchCount", BranchCount, mBranch);
      checkOutput("model MispredictCount", MispredictCount, mMisp);
`endif
    end
  end

  logic [31:0] ii;
  logic [31:0] lpce;
  logic        ltake;

  initial begin
    reset = 1'b1; UpdateE = 1'b0; PCE = '0; TargetE = '0;
    TakeBranchE = 1'b0; PredTakenE = 1'b0; PredTargetE = '0; PCF = 32'h100;

    // Reset held while an update is presented: reset must win
    applyStimulus(1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h100);
    idle(32'h100);
    checkOutput("reset PredTakenF", {31'd0, PredTakenF}, 32'd0);
    checkOutput("reset PredTargetF", PredTargetF, 32'h104);
    idle(32'hFFFF_FFFC);
    checkOutput("wrap PredTargetF", PredTargetF, 32'h0);

    // First taken resolution at 0x100 mispredicts and installs the entry
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104, 32'h100);
    checkOutput("install MispredictE", {31'd0, MispredictE}, 32'd1);
    checkOutput("install RedirectPCE", RedirectPCE, 32'h80);
    checkOutput("install pre-update PredTakenF", {31'd0, PredTakenF}, 32'd0);
    idle(32'h100);
    checkOutput("trained PredTakenF", {31'd0, PredTakenF}, 32'd1);
    checkOutput("trained PredTargetF", PredTargetF, 32'h80);

    // Three more taken (10->11->11->11), then two not-taken (10, 01)
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80, 32'h100);
      checkOutput("correct taken MispredictE", {31'd0, MispredictE}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h99C, 1'b0, 1'b1, 32'h80, 32'h100);
    checkOutput("not-taken MispredictE", {31'd0, MispredictE}, 32'd1);
    checkOutput("not-taken RedirectPCE", RedirectPCE, 32'h104);
    idle(32'h100);
    checkOutput("after 5th PredTakenF", {31'd0, PredTakenF}, 32'd1);
    checkOutput("after 5th target kept", PredTargetF, 32'h80);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h99C, 1'b0, 1'b1, 32'h80, 32'h100);
    idle(32'h100);
    checkOutput("after 6th PredTakenF", {31'd0, PredTakenF}, 32'd0);
    checkOutput("after 6th PredTargetF", PredTargetF, 32'h104);

    // Retrain to strong, then a conflicting miss at 0x140 replaces the entry
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104, 32'h100);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80, 32'h100);
    idle(32'h100);
    checkOutput("retrained PredTakenF", {31'd0, PredTakenF}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h140, 32'h40, 1'b0, 1'b0, 32'h144, 32'h100);
    checkOutput("correct not-taken MispredictE", {31'd0, MispredictE}, 32'd0);
    idle(32'h100);
    checkOutput("evicted PredTakenF", {31'd0, PredTakenF}, 32'd0);
    idle(32'h140);
    checkOutput("replaced weak PredTakenF", {31'd0, PredTakenF}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h140, 32'h40, 1'b1, 1'b0, 32'h144, 32'h140);
    idle(32'h140);
    checkOutput("0x140 taken PredTargetF", PredTargetF, 32'h40);

    // Wrong taken target; same-cycle fetch sees the old target
    applyStimulus(1'b0, 1'b1, 32'h140, 32'h300, 1'b1, 1'b1, 32'h200, 32'h140);
    checkOutput("target MispredictE", {31'd0, MispredictE}, 32'd1);
    checkOutput("target RedirectPCE", RedirectPCE, 32'h300);
    checkOutput("same-cycle old target", PredTargetF, 32'h40);
    idle(32'h143);
    checkOutput("new target low bits ignored", PredTargetF, 32'h300);
    idle(32'h103);
    checkOutput("tag miss PredTargetF", PredTargetF, 32'h107);

    // No update: mismatched predicted/actual must not flag or train
    applyStimulus(1'b0, 1'b0, 32'h140, 32'h500, 1'b0, 1'b1, 32'h300, 32'h140);
    checkOutput("idle MispredictE", {31'd0, MispredictE}, 32'd0);
    idle(32'h140);
    checkOutput("idle keeps PredTargetF", PredTargetF, 32'h300);

    // Mixed traffic across neighbouring indices, fetch aliased to the update PC
    for (int i = 0; i < 24; i++) begin
      ii    = 32'(i);
      lpce  = 32'h200 + (ii % 6) * 32'h44;
      ltake = (ii % 3) != 0;
      applyStimulus(1'b0, 1'b1, lpce, 32'h400 + (ii % 2), ltake, ltake ^ ((ii % 4) == 0),
                    32'h400, lpce);
    end

    // Reset with a simultaneous update clears the whole table
    applyStimulus(1'b1, 1'b1, 32'h140, 32'h300, 1'b1, 1'b1, 32'h300, 32'h140);
    idle(32'h140);
    checkOutput("final reset PredTakenF", {31'd0, PredTakenF}, 32'd0);
    checkOutput("final reset PredTargetF", PredTargetF, 32'h144);
`ifdef BP_STATS_EN
    checkOutput("final reset BranchCount", BranchCount, 32'd0);
    checkOutput("final reset MispredictCount", MispredictCount, 32'd0);
`endif

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter ENTRIES, default 16, giving the number of predictor entries (power of two, 4..64).
REQ-002 The module SHALL derive IDX_BITS = log2(ENTRIES); index = PC[IDX_BITS+1:2], tag = PC[31:IDX_BITS+2].
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The module SHALL have port PCF, input, 32 bits: the fetch-stage PC to predict.
REQ-006 The module SHALL have port PredTakenF, output, 1 bit: prediction for PCF.
REQ-007 The module SHALL have port PredTargetF, output, 32 bits: predicted target for PCF.
REQ-008 The module SHALL have port UpdateE, input, 1 bit: a conditional branch is resolved this cycle (Branch and valid in E).
REQ-009 The module SHALL have port PCE, input, 32 bits: PC of the resolving branch.
REQ-010 The module SHALL have port TargetE, input, 32 bits: computed branch target (PCE + B-immediate).
REQ-011 The module SHALL have port TakeBranchE, input, 1 bit: resolved outcome from the take-branch logic.
REQ-012 The module SHALL have port PredTakenE, input, 1 bit: PredTakenF carried down the pipeline with this branch.
REQ-013 The module SHALL have port PredTargetE, input, 32 bits: PredTargetF carried down the pipeline with this branch.
REQ-014 The module SHALL have port MispredictE, output, 1 bit: pipeline flush and redirect request.
REQ-015 The module SHALL have port RedirectPCE, output, 32 bits: the correct next PC when MispredictE is 1.

Function
REQ-016 Each entry SHALL hold a valid bit, a tag, a 32-bit target and a 2-bit saturating counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-017 PredTakenF SHALL equal valid & tag-match & ctr[1] for the entry indexed by PCF, combinational, with zero-cycle latency.
REQ-018 PredTargetF SHALL equal the stored target of the indexed entry when PredTakenF is 1, and PCF+4 otherwise.
REQ-019 On a clk edge with UpdateE=1 and a hit (valid & tag match), the counter SHALL step: +1 if TakeBranchE, -1 otherwise, saturating at 11 and 00.
REQ-020 On a hit with TakeBranchE=1, the target SHALL be overwritten with TargetE; on a hit with TakeBranchE=0, the target SHALL be kept.
REQ-021 On a clk edge with UpdateE=1 and a miss, the entry SHALL be replaced: valid=1, tag from PCE, target=TargetE, counter=10 if TakeBranchE, else 01.
REQ-022 With UpdateE=0, table state SHALL NOT change.
REQ-023 MispredictE SHALL be 1 iff UpdateE & ((PredTakenE != TakeBranchE) | (PredTakenE & TakeBranchE & (PredTargetE != TargetE))), combinational.
REQ-024 RedirectPCE SHALL be TargetE if TakeBranchE, else PCE+4 (modulo 2^32).
REQ-025 When PCF and PCE hit the same index in the same cycle, the fetch read SHALL return the pre-update entry; the update SHALL take effect from the next cycle.
REQ-026 PCF and PCE bits [1:0] SHALL be ignored.

Reset
REQ-027 On reset=1 at a clk edge, every valid bit SHALL clear and every counter SHALL be set to 01; tags and targets are don't-care.
REQ-028 Reset SHALL take priority over a simultaneous UpdateE.
REQ-029 After reset, PredTakenF SHALL be 0 and PredTargetF SHALL be PCF+4 for every PCF.
REQ-030 MispredictE SHALL depend only on its current inputs and SHALL be unaffected by reset.

Configuration
REQ-031 When BP_STATS_EN is defined, the module SHALL add outputs BranchCount[31:0] and MispredictCount[31:0].
REQ-032 With BP_STATS_EN defined, both counters SHALL reset to 0; BranchCount SHALL increment on each edge with UpdateE=1; MispredictCount SHALL increment on each edge with MispredictE=1; both SHALL wrap at 2^32.
REQ-033 When BP_STATS_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104.
REQ-035 UpdateE with PCE=0x100, TargetE=0x80, TakeBranchE=1, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80; next cycle PCF=0x100 gives PredTakenF=1, PredTargetF=0x80.
REQ-036 Four taken updates at 0x100 then two not-taken updates -> counter steps 10,11,11,11,10,01; PredTakenF=0 after the sixth update.
REQ-037 ENTRIES=16: train 0x100 taken, then one not-taken update at 0x140 (same index, different tag) -> entry replaced with counter 01; PCF=0x100 gives PredTakenF=0.
REQ-038 PredTakenE=1, TakeBranchE=1, PredTargetE=0x200, TargetE=0x300 -> MispredictE=1, RedirectPCE=0x300; same-cycle PCF=PCE returns the old target.
REQ-039 With BP_STATS_EN defined: 10 updates, of which 3 mispredict, then reset asserted together with an UpdateE -> BranchCount 10 and MispredictCount 3 before reset; both 0 and table invalid afterward.
